// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types for the round-robin grant controller
package rr_arb_pkg;

   typedef enum logic [0:0] {ST_IDLE, ST_GRANT} rr_state_t;

endpackage

// File: rtl/rr_grant_controller_if.sv
// rtl/rr_grant_controller_if.sv - request/grant bus between requesters and the grant controller
interface rr_grant_controller_if #(
   parameter int N_REQ = 8,
   parameter int W_IDX = $clog2(N_REQ)
);

   logic [N_REQ-1:0] req_in;
   logic             release_in;
   logic [N_REQ-1:0] gnt_out;
   logic [W_IDX-1:0] gnt_idx;
   logic             gnt_valid;

   modport master (
      output req_in,
      output release_in,
      input  gnt_out,
      input  gnt_idx,
      input  gnt_valid
   );

   modport slave (
      input  req_in,
      input  release_in,
      output gnt_out,
      output gnt_idx,
      output gnt_valid
   );

endinterface

// File: rtl/rr_grant_controller_lsb_enc.sv
// rtl/rr_grant_controller_lsb_enc.sv - LSB-first priority encoder
module NBitLsbPriorityEncoder #(
   parameter int W_DATA = 8,
   parameter int W_IDX  = $clog2(W_DATA)
) (
   input  logic [W_DATA-1:0] data,
   output logic [W_IDX-1:0]  index,
   output logic              available
);

   // Scan from the top down so the lowest set bit is the last one written and wins.
   always_comb begin
      index     = '0;
      available = 1'b0;
      for (int i = W_DATA - 1; i >= 0; i--) begin
         if (data[i]) begin
            index     = W_IDX'(i);
            available = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_controller.sv
// rtl/rr_grant_controller.sv - sequential round-robin grant controller with hold-until-release
module rr_grant_controller
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = 8,
   parameter int W_IDX = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_grant_controller_if.slave bus
);

   rr_state_t        state;
   logic [W_IDX-1:0] ptr;
   logic [W_IDX-1:0] base;
   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] masked;
   logic [W_IDX-1:0] idx_masked;
   logic [W_IDX-1:0] idx_unmasked;
   logic             masked_avail;
   logic             any_req;
   logic [W_IDX-1:0] winner;

   // While a grant is held the search starts after the holder; from idle it starts after the last holder.
   always_comb begin
      base = (state == ST_GRANT) ? bus.gnt_idx : ptr;
      mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         mask[i] = (W_IDX'(i) > base);
      end
      masked = bus.req_in & mask;
   end

   NBitLsbPriorityEncoder #(.W_DATA(N_REQ)) u_enc_masked (
      .data      (masked),
      .index     (idx_masked),
      .available (masked_avail)
   );

   NBitLsbPriorityEncoder #(.W_DATA(N_REQ)) u_enc_unmasked (
      .data      (bus.req_in),
      .index     (idx_unmasked),
      .available (any_req)
   );

   // Nothing above the base means wrap around to the lowest requester overall.
   always_comb begin
      winner = masked_avail ? idx_masked : idx_unmasked;
   end

   // Grant FSM: load on request from idle, hold until release, then rotate or fall idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         ptr           <= W_IDX'(N_REQ - 1);
         bus.gnt_out   <= '0;
         bus.gnt_idx   <= '0;
         bus.gnt_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state         <= ST_GRANT;
                  bus.gnt_idx   <= winner;
                  bus.gnt_out   <= N_REQ'(1) << winner;
                  bus.gnt_valid <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (bus.release_in) begin
                  ptr <= bus.gnt_idx;
                  if (any_req) begin
                     bus.gnt_idx   <= winner;
                     bus.gnt_out   <= N_REQ'(1) << winner;
                     bus.gnt_valid <= 1'b1;
                  end else begin
                     state         <= ST_IDLE;
                     bus.gnt_idx   <= '0;
                     bus.gnt_out   <= '0;
                     bus.gnt_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state         <= ST_IDLE;
               bus.gnt_idx   <= '0;
               bus.gnt_out   <= '0;
               bus.gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_controller.sv
// tb/tb_rr_grant_controller.sv - directed self-checking bench for rr_grant_controller
module tb_rr_grant_controller;

   localparam int N_REQ = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   rr_grant_controller_if #(.N_REQ(N_REQ)) bus ();

   rr_grant_controller #(.N_REQ(N_REQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [7:0] exp_out, input logic [2:0] exp_idx,
                              input logic exp_valid);
      check({tag, ".out"}, 32'(bus.gnt_out), 32'(exp_out));
      check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(exp_idx));
      check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(exp_valid));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst            = 1'b1;
      bus.req_in     = '0;
      bus.release_in = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_grant("reset", 8'h00, 3'd0, 1'b0);
      step();
      check_grant("idle_noreq", 8'h00, 3'd0, 1'b0);

      // First grant after reset
      bus.req_in = 8'b0000_0101;
      step();
      check_grant("first", 8'h01, 3'd0, 1'b1);

      // Back-to-back advance
      bus.release_in = 1'b1;
      step();
      check_grant("advance", 8'h04, 3'd2, 1'b1);

      // Wrap-around, then release with no requests falls idle
      step();
      check_grant("wrap", 8'h01, 3'd0, 1'b1);
      bus.req_in = 8'h00;
      step();
      check_grant("to_idle", 8'h00, 3'd0, 1'b0);
      bus.release_in = 1'b0;

      // Sole requester is re-granted on release
      bus.req_in = 8'h10;
      step();
      check_grant("sole_first", 8'h10, 3'd4, 1'b1);
      bus.release_in = 1'b1;
      step();
      check_grant("sole_regrant", 8'h10, 3'd4, 1'b1);
      bus.release_in = 1'b0;

      // Full rotation from a fresh pointer, continuing until index 3 is held
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req_in     = 8'hFF;
      bus.release_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         check_grant($sformatf("rot%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1);
      end
      bus.release_in = 1'b0;

      // Hold without release regardless of request changes
      bus.req_in = 8'h01;
      for (int k = 0; k < 5; k++) begin
         step();
         check_grant($sformatf("hold_a%0d", k), 8'h08, 3'd3, 1'b1);
      end
      bus.req_in = 8'h00;
      for (int k = 0; k < 5; k++) begin
         step();
         check_grant($sformatf("hold_b%0d", k), 8'h08, 3'd3, 1'b1);
      end

      // Release to idle (pointer becomes 3), then grant index 5
      bus.release_in = 1'b1;
      step();
      check_grant("idle2", 8'h00, 3'd0, 1'b0);
      bus.release_in = 1'b0;
      bus.req_in     = 8'h20;
      step();
      check_grant("hold5", 8'h20, 3'd5, 1'b1);

      // Reset wins over release mid-grant
      rst            = 1'b1;
      bus.release_in = 1'b1;
      step();
      check_grant("rst_mid", 8'h00, 3'd0, 1'b0);
      rst            = 1'b0;
      bus.release_in = 1'b0;
      bus.req_in     = 8'h81;
      step();
      check_grant("after_rst", 8'h01, 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
